// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the datapath select codes driven by the controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of the current memory access and flags expiry when
// the access has waited MEM_WAIT_MAX cycles and is still not ready.
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  input  logic state_change,
  output logic expire
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MEM_WAIT_MAX);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // A limit of zero disables the abort entirely.
  assign expire = (MEM_WAIT_MAX > 0) && active && !mem_ready && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (!active || mem_ready || state_change || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath with memory-wait abort.
//   state       | meaning
//   FETCH (0)   | read instruction at PC, PC+4 -> PC on mem_ready
//   DECODE(1)   | branch target precompute, dispatch on opcode
//   MEMADR(2)   | base + offset address for LW/SW
//   MEMRD (3)   | data read          MEMWB (4) | load writeback
//   MEMWR (5)   | data write         EXEC  (6) | R-type ALU op
//   ALUWB (7)   | R-type writeback   BRANCH(8) | beq compare/PC update
//   ADDIEX(9)   | addi ALU op        ADDIWB(10)| addi writeback
//   JUMP  (11)  | jump PC update
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_out
);

  state_e state_q, state_d;
  logic   mem_timeout_q;
  logic   expire;

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .WAIT_CNT_W  (WAIT_CNT_W)
  ) u_wait (
    .clk         (clk),
    .reset       (reset),
    .active      (is_mem_state(state_q)),
    .mem_ready   (mem_ready),
    .state_change(state_d != state_q),
    .expire      (expire)
  );

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_op        = ALU_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    mem_timeout   = mem_timeout_q;
    state_out     = state_q;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        // Expiry only fires with mem_ready low, so an aborted fetch never writes.
        if (expire) begin
          state_d = S_FETCH;
        end else if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (expire) begin
          state_d = S_FETCH;
        end else if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (expire || mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset blanks every output, including the request, in the same cycle.
    if (reset) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
      mem_timeout   = 1'b0;
      state_out     = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (expire) begin
        mem_timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-built stall/timeout/reset
// sequences, then randomized traffic against an instruction-script reference model.
module tb_multicycle_ctrl;

  localparam int MAXW = 15;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_BAD  = 6'b111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_out;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    int         st;
    logic       tflag;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op, mem_timeout;
  logic [3:0] state_out;
  outs_t      act;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW), .WAIT_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_out(state_out)
  );

  assign act = {mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                illegal_op, mem_timeout, state_out};

  // Output table for each state as listed by the controller's definition.
  function automatic outs_t exp_out(int st, logic [5:0] op, logic rdy, logic rst, logic tflag);
    outs_t o;
    o = '0;
    if (rst) return o;
    o.state_out   = st[3:0];
    o.mem_timeout = tflag;
    case (st)
      0:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      1:  begin
            o.alu_src_b  = 2'b11;
            o.illegal_op = !(op inside {T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J});
          end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_req = 1; o.iord = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      5:  begin o.mem_req = 1; o.mem_write = 1; o.iord = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7:  begin o.reg_write = 1; o.reg_dst = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_write_cond = 1; end
      9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      10: begin o.reg_write = 1; end
      11: begin o.pc_source = 2'b10; o.pc_write = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Called at posedge+1: drive inputs, compare at the falling edge, advance one cycle.
  task automatic drive_check(input logic r, input logic [5:0] op, input logic rdy,
                             input outs_t exp, input string name);
    reset     = r;
    opcode    = op;
    mem_ready = rdy;
    #4;
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (state got %0d want %0d)",
               name, act, exp, act.state_out, exp.state_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic r, input logic [5:0] op, input logic rdy, input int st,
                     input logic tflag, input string name);
    drive_check(r, op, rdy, exp_out(st, op, rdy, r, tflag), name);
  endtask

  // Reference model: an instruction is a script of states chosen at decode;
  // memory steps linger while not ready and abort after MAXW stalled cycles.
  int   m_st;
  int   m_stall;
  logic m_flag;
  int   m_plan[$];

  task automatic model_step(input logic [5:0] op, input logic rdy, input logic r);
    if (r) begin
      m_st = 0; m_stall = 0; m_flag = 0; m_plan.delete();
      return;
    end
    if ((m_st == 0 || m_st == 3 || m_st == 5) && !rdy) begin
      if (MAXW > 0 && m_stall == MAXW) begin
        m_flag = 1; m_stall = 0; m_plan.delete(); m_st = 0;
      end else begin
        m_stall++;
      end
      return;
    end
    m_stall = 0;
    if (m_st == 0) begin
      m_st = 1;
      return;
    end
    if (m_st == 1) begin
      m_plan.delete();
      case (op)
        T_LW:    begin m_plan.push_back(2); m_plan.push_back(3); m_plan.push_back(4); end
        T_SW:    begin m_plan.push_back(2); m_plan.push_back(5); end
        T_R:     begin m_plan.push_back(6); m_plan.push_back(7); end
        T_BEQ:   m_plan.push_back(8);
        T_ADDI:  begin m_plan.push_back(9); m_plan.push_back(10); end
        T_J:     m_plan.push_back(11);
        default: ;
      endcase
    end
    m_st = (m_plan.size() > 0) ? m_plan.pop_front() : 0;
  endtask

  vec_t tbl[$];

  function automatic void add(logic r, logic [5:0] op, logic rdy, int st, logic tf);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.tflag = tf;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [5:0] rop;
    logic       rr, rrdy;
    int         burst;
    logic [5:0] ops[6];

    ops[0] = T_R; ops[1] = T_LW; ops[2] = T_SW;
    ops[3] = T_BEQ; ops[4] = T_ADDI; ops[5] = T_J;

    // reset, LW, R, BEQ, J, SW with stalls, ADDI, illegal, opcode change ignored
    add(1, T_LW, 1, 0, 0);  add(1, T_LW, 1, 0, 0);
    add(0, T_LW, 1, 0, 0);  add(0, T_LW, 1, 1, 0);  add(0, T_LW, 1, 2, 0);
    add(0, T_LW, 1, 3, 0);  add(0, T_LW, 1, 4, 0);
    add(0, T_R, 1, 0, 0);   add(0, T_R, 1, 1, 0);   add(0, T_R, 1, 6, 0);  add(0, T_R, 1, 7, 0);
    add(0, T_BEQ, 1, 0, 0); add(0, T_BEQ, 1, 1, 0); add(0, T_BEQ, 1, 8, 0);
    add(0, T_J, 1, 0, 0);   add(0, T_J, 1, 1, 0);   add(0, T_J, 1, 11, 0);
    add(0, T_SW, 1, 0, 0);  add(0, T_SW, 1, 1, 0);  add(0, T_SW, 1, 2, 0);
    add(0, T_SW, 0, 5, 0);  add(0, T_SW, 0, 5, 0);  add(0, T_SW, 0, 5, 0); add(0, T_SW, 1, 5, 0);
    add(0, T_ADDI, 1, 0, 0); add(0, T_ADDI, 1, 1, 0); add(0, T_ADDI, 1, 9, 0); add(0, T_ADDI, 1, 10, 0);
    add(0, T_BAD, 1, 0, 0); add(0, T_BAD, 1, 1, 0);
    add(0, T_R, 1, 0, 0);   add(0, T_R, 1, 1, 0);   add(0, T_J, 1, 6, 0);  add(0, T_LW, 1, 7, 0);
    add(0, T_LW, 1, 0, 0);

    #1;
    foreach (tbl[i]) run(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].tflag, "table");

    // Fetch abort: MAXW stalls then one more stalled cycle expires; flag is sticky.
    run(1, T_R, 0, 0, 0, "to_rst");
    for (int i = 0; i < MAXW; i++) run(0, T_R, 0, 0, 0, "to_stall");
    run(0, T_R, 0, 0, 0, "to_expire");
    run(0, T_R, 0, 0, 1, "to_refetch");
    run(0, T_R, 1, 0, 1, "to_fetch_ok");
    run(0, T_R, 1, 1, 1, "to_decode");

    // Ready arriving on the limit cycle completes normally.
    run(1, T_R, 0, 0, 0, "edge_rst");
    for (int i = 0; i < MAXW; i++) run(0, T_R, 0, 0, 0, "edge_stall");
    run(0, T_R, 1, 0, 0, "edge_ready");
    run(0, T_R, 1, 1, 0, "edge_decode");

    // Read abort skips the writeback; a reset in MEMRD then clears the flag.
    run(1, T_LW, 1, 0, 0, "rd_rst");
    run(0, T_LW, 1, 0, 0, "rd_fetch");
    run(0, T_LW, 1, 1, 0, "rd_decode");
    run(0, T_LW, 1, 2, 0, "rd_memadr");
    for (int i = 0; i <= MAXW; i++) run(0, T_LW, 0, 3, 0, "rd_stall");
    run(0, T_LW, 1, 0, 1, "rd_abort");
    run(0, T_LW, 1, 1, 1, "rd2_decode");
    run(0, T_LW, 1, 2, 1, "rd2_memadr");
    run(0, T_LW, 0, 3, 1, "rd2_memrd");
    run(1, T_LW, 0, 0, 0, "rd2_reset");
    run(0, T_LW, 0, 0, 0, "post_reset");

    // Randomized traffic against the reference model.
    m_st = 0; m_stall = 0; m_flag = 0; m_plan.delete();
    rop = T_R; burst = 0;
    for (int c = 0; c < 1500; c++) begin
      rr = (c == 0) || ($urandom_range(0, 99) == 0);
      if (burst > 0) begin
        rrdy = 1'b0;
        burst--;
      end else begin
        if ($urandom_range(0, 49) == 0) burst = $urandom_range(8, 20);
        rrdy = ($urandom_range(0, 3) != 0);
      end
      if (m_st == 0) begin
        if ($urandom_range(0, 7) == 0) rop = 6'($urandom);
        else rop = ops[$urandom_range(0, 5)];
      end
      drive_check(rr, rop, rrdy, exp_out(m_st, rop, rrdy, rr, m_flag), "random");
      model_step(rop, rrdy, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath built from the shared adder, mux, shifter, sign-extend and jump-address blocks.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives every mux select, register-write enable and the PC update.
- Handshakes with a variable-latency unified memory and aborts a hung access with a timeout.

Parameters:
- MEM_WAIT_MAX, 15: maximum wait cycles per memory access before abort; 0 disables the timeout.
- WAIT_CNT_W, 4: width of the wait counter; must satisfy 2^WAIT_CNT_W > MEM_WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction[31:26] from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  access is a write; qualifies mem_req.
- iord  out  1  memory address select: 0=PC, 1=ALU result register.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if the ALU zero flag is set (beq).
- pc_source  out  2  00=ALU result, 01=ALU-out register, 10=jump address.
- alu_src_a  out  1  0=PC, 1=register A.
- alu_src_b  out  2  00=register B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2.
- alu_op  out  2  00=add, 01=subtract, 10=decode funct.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALU-out, 1=memory data register.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- mem_timeout  out  1  sticky flag; cleared only by reset.
- state_out  out  4  current state encoding, for debug.

Behaviour:
- Reset (synchronous): state=FETCH, wait counter=0, mem_timeout=0.
  - While reset is high, every output is forced to 0, including mem_req.
- Outputs are Moore (decoded from state only), except ir_write and pc_write in FETCH, which are gated by mem_ready.
- Any output not listed for a state is 0.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- States, encodings and outputs:
  - FETCH(0): mem_req, alu_src_b=01.
    - mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
    - Otherwise stay in FETCH.
  - DECODE(1): alu_src_b=11.
    - Next state: LW or SW -> MEMADR; R -> EXEC; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP.
    - Any other opcode: illegal_op=1, next state FETCH.
  - MEMADR(2): alu_src_a=1, alu_src_b=10.
    - Next state: LW -> MEMRD; SW -> MEMWR.
  - MEMRD(3): mem_req, iord.
    - Next state on mem_ready: MEMWB.
  - MEMWB(4): reg_write, mem_to_reg. Next state FETCH.
  - MEMWR(5): mem_req, mem_write, iord.
    - Next state on mem_ready: FETCH.
  - EXEC(6): alu_src_a=1, alu_op=10. Next state ALUWB.
  - ALUWB(7): reg_write, reg_dst. Next state FETCH.
  - BRANCH(8): alu_src_a=1, alu_op=01, pc_source=01, pc_write_cond. Next state FETCH.
  - ADDIEX(9): alu_src_a=1, alu_src_b=10. Next state ADDIWB.
  - ADDIWB(10): reg_write. Next state FETCH.
  - JUMP(11): pc_source=10, pc_write. Next state FETCH.
  - Encodings 12-15: unreachable; if entered, next state FETCH.
- opcode is sampled in DECODE and MEMADR only. Changes in other states are ignored.
- Wait counter:
  - Applies in the memory states FETCH, MEMRD and MEMWR.
  - Increments each cycle with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
- Timeout, when MEM_WAIT_MAX>0 and counter==MEM_WAIT_MAX with mem_ready=0:
  - mem_timeout<=1, counter<=0, next state FETCH.
  - The aborted access produces no pc_write, ir_write or reg_write.
  - A timeout in FETCH re-fetches the same PC.
- If mem_ready=1 arrives in the same cycle the counter hits its limit, mem_ready wins: normal completion, no timeout.
- Minimum cycles per instruction with mem_ready held at 1: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
- Reset asserted mid-instruction (for example in MEMWR) forces all outputs to 0 in that cycle; FETCH follows once reset deasserts.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants;
  - state encodings as a 4-bit enum;
  - alu_op, alu_src_b and pc_source codes.
- One natural sub-module, mem_wait_timer: the wait counter plus timeout compare.
  - Inputs: clk, reset, active, mem_ready, state_change.
  - Output: expire.

Test Plan:
- LW, mem_ready tied 1 -> state_out sequence 0,1,2,3,4,0.
  - ir_write and pc_write high in cycle 1.
  - mem_to_reg=1 and reg_write=1 only in state 4.
- R-type, then BEQ, then J, mem_ready tied 1:
  - R-type -> 4 cycles, alu_op=10 in state 6, reg_dst=1 in state 7.
  - BEQ -> 3 cycles, pc_write_cond=1 with pc_source=01.
  - J -> 3 cycles, pc_write=1 with pc_source=10.
- SW with mem_ready low for 3 cycles in MEMWR -> mem_req=mem_write=iord=1 held for 4 cycles; FETCH next; reg_write never asserted.
- MEM_WAIT_MAX=15, mem_ready held 0 in FETCH:
  - After 15 stalled cycles -> mem_timeout=1 (sticky) and FETCH re-entered; pc_write stays 0.
  - Same setup with mem_ready=1 on the 15th stalled cycle -> no timeout, DECODE next.
- opcode=111111 -> illegal_op high exactly in the DECODE cycle; then FETCH; no reg_write, pc_write or mem_write.
- reset pulsed for 1 cycle while in MEMRD -> all outputs 0 that cycle; next cycle state_out=0 with mem_req=1; mem_timeout=0.
